// File: rtl/msg_streamer.sv
// msg_streamer: selects one of NUM_CH external message ROMs, walks its addresses and sends
// each word as an async serial frame (start 0, data LSB-first, stop 1), BAUD_DIV cycles/bit.
// Optional build macro MSG_TERM_EN: an all-zero fetched word ends the message untransmitted.
module msg_streamer #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MSG_LEN  = 16,
    parameter int unsigned BAUD_DIV = 4,
    localparam int unsigned ADDR_W  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic                     write,
    input  logic                     auto,
    input  logic [NUM_CH-1:0]        sel,
    input  logic [NUM_CH*DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0]        rom_addr,
    output logic [DATA_W-1:0]        data_latch,
    output logic                     serial_out,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned BIT_W  = $clog2(DATA_W + 2);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MSG_LEN - 1);
    localparam logic [BAUD_W-1:0] LastBaud = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  StopBit  = BIT_W'(DATA_W + 1);
    localparam logic [BIT_W-1:0]  LastData = BIT_W'(DATA_W);

    typedef enum logic [2:0] {StIdle, StLoad, StFetch, StShift, StDone} state_e;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   latch_q, latch_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic                ser_q, ser_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                write_q, write_qq, wedge_q;

    logic [DATA_W-1:0]   words [NUM_CH];
    logic [DATA_W-1:0]   word;
    logic [CH_W-1:0]     lowest;

    // Two-stage sampling of write; wedge_q is the registered rising-edge flag.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            write_q  <= 1'b0;
            write_qq <= 1'b0;
            wedge_q  <= 1'b0;
        end else begin
            write_q  <= write;
            write_qq <= write_q;
            wedge_q  <= write_q & ~write_qq;
        end
    end

    // Split the ROM bus per channel, pick the latched channel, find lowest set select bit.
    always_comb begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            words[c] = rom_data[c*DATA_W +: DATA_W];
        end
        word   = words[ch_q];
        lowest = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (sel[i]) lowest = CH_W'(i);
        end
    end

    // Message/frame sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        latch_d = latch_q;
        sh_d    = sh_q;
        ser_d   = ser_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        case (state_q)
            StIdle: begin
                ser_d = 1'b1;
                if ((wedge_q || auto) && (sel != '0)) state_d = StLoad;
            end
            StLoad: begin
                ch_d    = lowest;
                addr_d  = '0;
                state_d = StFetch;
            end
            StFetch: begin
                latch_d = word;
                sh_d    = word;
                baud_d  = '0;
                bit_d   = '0;
`ifdef MSG_TERM_EN
                if (word == '0) begin
                    addr_d  = '0;
                    ser_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    ser_d   = 1'b0;
                    state_d = StShift;
                end
`else
                ser_d   = 1'b0;
                state_d = StShift;
`endif
            end
            StShift: begin
                if (baud_q == LastBaud) begin
                    baud_d = '0;
                    if (bit_q == StopBit) begin
                        ser_d = 1'b1;
                        if (addr_q == LastAddr) begin
                            addr_d  = '0;
                            state_d = StDone;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = StFetch;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        if (bit_q == LastData) begin
                            ser_d = 1'b1;
                        end else begin
                            ser_d = sh_q[0];
                            sh_d  = sh_q >> 1;
                        end
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            StDone: begin
                ser_d   = 1'b1;
                addr_d  = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= StIdle;
            ch_q    <= '0;
            addr_q  <= '0;
            latch_q <= '0;
            sh_q    <= '0;
            ser_q   <= 1'b1;
            baud_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            latch_q <= latch_d;
            sh_q    <= sh_d;
            ser_q   <= ser_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
        end
    end

    assign rom_addr   = addr_q;
    assign data_latch = latch_q;
    assign serial_out = ser_q;
    assign busy       = (state_q == StLoad) || (state_q == StFetch) || (state_q == StShift);
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_msg_streamer.sv
// tb_msg_streamer: randomized ROM contents checked cycle-by-cycle against a frame-level model.
// Follows MSG_TERM_EN in the same way as the design.
module tb_msg_streamer;

    localparam int NUM_CH   = 4;
    localparam int DATA_W   = 8;
    localparam int MSG_LEN  = 16;
    localparam int BAUD_DIV = 4;
    localparam int ADDR_W   = 4;
    localparam int WORD_CYC = 1 + (DATA_W + 2) * BAUD_DIV;

    logic                     sysclk = 1'b0;
    logic                     reset, write, auto;
    logic [NUM_CH-1:0]        sel;
    logic [NUM_CH*DATA_W-1:0] rom_data;
    logic [ADDR_W-1:0]        rom_addr;
    logic [DATA_W-1:0]        data_latch;
    logic                     serial_out, busy, done;

    logic [DATA_W-1:0] mem [NUM_CH][MSG_LEN];
    int checks = 0;
    int errors = 0;

    msg_streamer #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .MSG_LEN (MSG_LEN),
        .BAUD_DIV(BAUD_DIV)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .write     (write),
        .auto      (auto),
        .sel       (sel),
        .rom_data  (rom_data),
        .rom_addr  (rom_addr),
        .data_latch(data_latch),
        .serial_out(serial_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 sysclk = ~sysclk;

    // Combinational ROMs.
    always @* begin
        for (int c = 0; c < NUM_CH; c++) rom_data[c*DATA_W +: DATA_W] = mem[c][rom_addr];
    end

    function automatic int msg_words(input int c);
`ifdef MSG_TERM_EN
        for (int i = 0; i < MSG_LEN; i++) if (mem[c][i] == '0) return i;
`endif
        return MSG_LEN;
    endfunction

    task automatic fill_random();
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < MSG_LEN; a++) mem[c][a] = DATA_W'($urandom_range(1, 255));
    endtask

    // Pulse write at a negedge; busy (LOAD) must appear 3 negedges later.
    task automatic start_write(output bit ok);
        int lat = 0;
        write = 1'b1;
        do begin
            @(negedge sysclk);
            lat++;
            if (lat == 1) write = 1'b0;
        end while (!busy && lat < 20);
        checks++;
        ok = busy;
        if (lat != 3 || !busy) begin
            errors++;
            $display("FAIL start_latency: got %0d cycles (busy=%b), want 3", lat, busy);
        end
    endtask

    // Entered at the negedge of the LOAD cycle; checks every cycle through the DONE cycle.
    task automatic check_message(input int c, input string tag, input logic [NUM_CH-1:0] mid_sel,
                                 input bit mid_write, input bit drop_auto);
        bit exp_ser[$];
        int exp_addr[$];
        int exp_word[$];
        int n = msg_words(c);
        int bad = 0;
        for (int w = 0; w < n; w++) begin
            exp_ser.push_back(1'b1); exp_addr.push_back(w); exp_word.push_back(-1);
            for (int b = 0; b < DATA_W + 2; b++) begin
                logic [DATA_W-1:0] wv = mem[c][w];
                bit v = (b == 0) ? 1'b0 : (b == DATA_W + 1) ? 1'b1 : wv[b-1];
                repeat (BAUD_DIV) begin
                    exp_ser.push_back(v); exp_addr.push_back(w); exp_word.push_back(int'(wv));
                end
            end
        end
        if (n < MSG_LEN) begin
            exp_ser.push_back(1'b1); exp_addr.push_back(n); exp_word.push_back(-1);
        end
        for (int i = 0; i < exp_ser.size(); i++) begin
            int ew = exp_word[i];
            @(negedge sysclk);
            checks++;
            if (serial_out !== exp_ser[i] || rom_addr !== ADDR_W'(exp_addr[i]) || busy !== 1'b1
                || done !== 1'b0 || (ew >= 0 && data_latch !== DATA_W'(ew))) begin
                errors++;
                if (bad++ < 8)
                    $display("FAIL %s cyc %0d: ser=%b addr=%0d latch=%h busy=%b done=%b, want ser=%b addr=%0d latch=%0h busy=1 done=0",
                             tag, i, serial_out, rom_addr, data_latch, busy, done, exp_ser[i],
                             exp_addr[i], ew);
            end
            if (i == WORD_CYC) begin
                if (mid_sel != '0) sel = mid_sel;
                if (mid_write) write = 1'b1;
                if (drop_auto) auto = 1'b0;
            end
            if (i == WORD_CYC + 1) write = 1'b0;
        end
        @(negedge sysclk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || serial_out !== 1'b1 || rom_addr !== '0) begin
            errors++;
            $display("FAIL %s done_cycle: done=%b busy=%b ser=%b addr=%0d, want 1 0 1 0",
                     tag, done, busy, serial_out, rom_addr);
        end
    endtask

    // Watch for a number of cycles that nothing starts.
    task automatic expect_quiet(input string tag, input int cycles);
        bit bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge sysclk);
            if (busy !== 1'b0 || done !== 1'b0 || serial_out !== 1'b1) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s quiet: activity seen (busy=%b done=%b ser=%b), want idle",
                     tag, busy, done, serial_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; write = 1'b0; auto = 1'b0; sel = '0;
        repeat (3) @(negedge sysclk);
        checks++;
        if (serial_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rom_addr !== '0
            || data_latch !== '0) begin
            errors++;
            $display("FAIL reset_values: ser=%b busy=%b done=%b addr=%0d latch=%h, want 1 0 0 0 00",
                     serial_out, busy, done, rom_addr, data_latch);
        end
        reset = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic test_basic();
        bit ok;
        fill_random();
        mem[1][0] = 8'hA5;
        sel = 4'b0010;
        start_write(ok);
        if (ok) check_message(1, "basic_ch1", '0, 1'b0, 1'b0);
        expect_quiet("basic_after", 10);
    endtask

    task automatic test_sel_priority();
        bit ok;
        fill_random();
        sel = 4'b0110;
        start_write(ok);
        if (ok) check_message(1, "sel_priority", 4'b1000, 1'b0, 1'b0);
        expect_quiet("sel_priority_after", 5);
    endtask

    task automatic test_auto();
        int k = 0;
        fill_random();
        sel  = 4'b0001;
        auto = 1'b1;
        do begin @(negedge sysclk); k++; end while (!busy && k < 10);
        checks++;
        if (k != 1) begin
            errors++;
            $display("FAIL auto_start: busy after %0d cycles, want 1", k);
        end
        check_message(0, "auto_msg1", '0, 1'b0, 1'b0);
        @(negedge sysclk);
        checks++;
        if (busy !== 1'b0 || serial_out !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL auto_gap_idle: busy=%b ser=%b done=%b, want 0 1 0", busy, serial_out, done);
        end
        @(negedge sysclk);
        checks++;
        if (busy !== 1'b1 || serial_out !== 1'b1) begin
            errors++;
            $display("FAIL auto_gap_load: busy=%b ser=%b, want 1 1", busy, serial_out);
        end
        check_message(0, "auto_msg2_drop", '0, 1'b0, 1'b1);
        expect_quiet("auto_stopped", 30);
    endtask

    task automatic test_sel_zero();
        sel   = '0;
        write = 1'b1;
        @(negedge sysclk);
        write = 1'b0;
        expect_quiet("sel_zero", 20);
    endtask

    task automatic test_write_busy();
        bit ok;
        fill_random();
        sel = 4'b0100;
        start_write(ok);
        if (ok) check_message(2, "write_busy", '0, 1'b1, 1'b0);
        expect_quiet("write_busy_no_requeue", 20);
    endtask

    task automatic test_zero_word();
        bit ok;
        fill_random();
        mem[0][0] = 8'h41; mem[0][1] = 8'h42; mem[0][2] = 8'h00;
        sel = 4'b0001;
        start_write(ok);
        if (ok) check_message(0, "zero_word", '0, 1'b0, 1'b0);
        expect_quiet("zero_word_after", 5);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k = 0;
        fill_random();
        sel = 4'b1000;
        start_write(ok);
        while (!(busy && rom_addr == 2 && serial_out == 1'b0) && k < 400) begin
            @(negedge sysclk);
            k++;
        end
        checks++;
        if (k >= 400) begin
            errors++;
            $display("FAIL reset_mid_reach: no start bit of word 2 in %0d cycles", k);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            checks++;
            if (serial_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rom_addr !== '0
                || data_latch !== '0) begin
                errors++;
                $display("FAIL reset_mid cyc %0d: ser=%b busy=%b done=%b addr=%0d latch=%h, want 1 0 0 0 00",
                         i, serial_out, busy, done, rom_addr, data_latch);
            end
        end
        reset = 1'b0;
        expect_quiet("reset_mid_after", 20);
    endtask

    initial begin
        fill_random();
        test_reset();
        test_basic();
        test_sel_priority();
        test_auto();
        test_sel_zero();
        test_write_busy();
        test_zero_word();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
